// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width encodings for loads/stores
//   - lsu_state_t : FSM state encoding (IDLE, BUS, WB)
//   - err_code_t  : error code reported on err_code_o
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WB   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

endpackage

// File: rtl/lsu_load_align.sv
// load_align: picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it according to the RV32I load funct3.
// Ports:
//   rdata_i   [31:0] read word from the bus
//   addr_lo_i [1:0]  byte offset of the load within the word
//   funct3_i  [2:0]  load width/sign encoding
//   result_o  [31:0] value to write into the register file
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfwords are only ever accepted at offset 0 or 2, so bit 1 selects.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'd0, byte_sel};
      F3_LHU:  result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit. Accepts one memory operation at a time,
// runs a single-outstanding word-addressed bus access, then writes aligned
// and extended load data to the register file.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i/req_ready_o            request handshake from execute
//   req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i  request fields
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o     bus request
//   bus_ack_i, bus_rdata_i             bus completion and read data
//   rf_we_o, rf_rd_o, rf_rd_data_o     register-file write port
//   busy_o                             FSM not in IDLE
//   err_o, err_code_o                  one-cycle error pulse, sticky code
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high exactly when the FSM is in
// IDLE, so at most one operation is ever in flight. The bus side holds
// bus_req_o with stable address/data until bus_ack_i is sampled high.
module lsu
  import lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  lsu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [1:0]       off_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic [31:0]      rd_data_q;
  logic             err_q;
  err_code_t        err_code_q;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_illegal;
  logic        req_misalign;
  logic [31:0] load_result;

  // Request decode: byte enables and lane-replicated store data depend only
  // on the size bits funct3[1:0] and the byte offset.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_addr_i[1:0];
        req_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        req_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = req_wdata_i;
      end
    endcase
    // Unsigned variants (1xx) exist only for loads.
    req_illegal  = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                   (req_funct3_i[2] && req_we_i);
    req_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  load_align u_load_align (
    .rdata_i   (bus_rdata_i),
    .addr_lo_i (off_q),
    .funct3_i  (f3_q),
    .result_o  (load_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      rd_q       <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= {req_addr_i[31:2], 2'b00};
            off_q   <= req_addr_i[1:0];
            be_q    <= req_be;
            wdata_q <= req_wdata;
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            rd_q    <= req_rd_i;
            if (req_illegal) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_FUNCT3;
            end else if (req_misalign) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_MISALIGN;
            end else begin
              state_q <= BUS;
              cnt_q   <= '0;
            end
          end
        end
        BUS: begin
          // Ack wins over timeout when both land in the same cycle.
          if (bus_ack_i) begin
            if (we_q || (rd_q == 5'd0)) begin
              state_q <= IDLE;
            end else begin
              rd_data_q <= load_result;
              state_q   <= WB;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q    <= IDLE;
              err_q      <= 1'b1;
              err_code_q <= ERR_TIMEOUT;
            end
          end
        end
        WB:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign bus_req_o    = (state_q == BUS);
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_be_o     = be_q;
  assign bus_wdata_o  = wdata_q;
  assign rf_we_o      = (state_q == WB);
  assign rf_rd_o      = rd_q;
  assign rf_rd_data_o = rd_data_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core; sits directly upstream of the register-file write port. Accepts one memory operation at a time from execute, drives a single-outstanding word-addressed data bus, then aligns and sign- or zero-extends load data. Writes the result into the register file through `rf_we_o`, `rf_rd_o` and `rf_rd_data_o`. Flags misaligned accesses, illegal width encodings and bus timeouts.

## Interface
- `BUS_TIMEOUT`, default 255: maximum cycles spent waiting for `bus_ack_i` before abort; must be ≥1.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: execute presents an operation.
- `req_ready_o` out 1: high only in IDLE; transfer occurs when `req_valid_i && req_ready_o`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I width field (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, taken from rs2.
- `req_rd_i` in 5: load destination register.
- `bus_req_o` out 1: bus request, held until ack.
- `bus_we_o` out 1: bus write.
- `bus_addr_o` out 32: `{addr[31:2],2'b00}`.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_ack_i` in 1: bus completes the access this cycle; `bus_rdata_i` valid.
- `bus_rdata_i` in 32: read word.
- `rf_we_o`, `rf_rd_o` (5), `rf_rd_data_o` (32) out: register-file write port.
- `busy_o` out 1: state ≠ IDLE.
- `err_o` out 1: one-cycle error pulse.
- `err_code_o` out 2: last error. 01 = misaligned, 10 = illegal funct3, 11 = timeout. Held until the next error.

## Operation
- States:
  - IDLE: `req_ready_o` = 1.
  - BUS: `bus_req_o` = 1.
  - WB: `rf_we_o` = 1.
- IDLE, on accept: latch addr, funct3, we, rd and formatted wdata/be, then check the request.
  - Illegal funct3 is 011, 11x, or 1xx with a store. Pulse `err_o` with code 10, no bus access, stay in IDLE.
  - Misaligned is a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 00. Pulse `err_o` with code 01, no bus access, stay in IDLE.
  - Otherwise go to BUS and clear the timeout counter.
- BUS:
  - Bus outputs are driven from registers and are stable for the whole request.
  - On `bus_ack_i`: a store goes to IDLE. A load captures the aligned result and goes to WB, or goes to IDLE if rd = 0 (x0 is never written).
  - Without ack, the counter increments. When it reaches `BUS_TIMEOUT`: drop `bus_req_o`, pulse `err_o` with code 11, go to IDLE, no writeback.
- WB: `rf_we_o` = 1 for exactly one cycle with the registered rd and data, then IDLE.
- Byte enables and store data:
  - Byte: `be` = 0001 << addr[1:0]; `wdata` = {4{d[7:0]}}.
  - Halfword: `be` = addr[1] ? 1100 : 0011; `wdata` = {2{d[15:0]}}.
  - Word: `be` = 1111; `wdata` = d.
  - Loads drive `be` the same way; `bus_we_o` = 0.
- Load alignment: select byte `rdata[8*a+7:8*a]` or half `rdata[16*a1+15:16*a1]`.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Only one operation in flight; no request is accepted outside IDLE.

## Timing
- Reset (asynchronous, immediate) forces:
  - state = IDLE, counter = 0.
  - `bus_req_o`, `bus_we_o`, `rf_we_o`, `err_o` = 0.
  - `bus_addr_o`, `bus_be_o`, `bus_wdata_o`, `rf_rd_o`, `rf_rd_data_o`, `err_code_o` = 0.
  - `busy_o` = 0, `req_ready_o` = 1.
- Reset mid-BUS abandons the access with no error pulse.
- Accept in cycle 0 makes `bus_req_o` = 1 from cycle 1. An ack sampled in cycle k (k ≥ 1, same-cycle ack allowed) gives:
  - Load: `rf_we_o` in cycle k+1 and `req_ready_o` in cycle k+2.
  - Store: `req_ready_o` in cycle k+1.
- Best-case latency: load 3 cycles accept-to-accept, store 2.
- Error pulses:
  - Misaligned and illegal funct3: `err_o` in cycle 1; `req_ready_o` remains 1, so the next request can be accepted in cycle 1.
  - Timeout: `err_o` asserts in the cycle after the `BUS_TIMEOUT`-th unacked BUS cycle, together with the return to IDLE.
- `bus_ack_i` outside BUS is ignored.
- An ack in the same cycle the counter reaches `BUS_TIMEOUT` counts as a completion, not a timeout.

## Structure
- `lsu_pkg` holds:
  - `funct3` localparams (LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101).
  - `lsu_state_t` enum {IDLE, BUS, WB}.
  - `err_code_t` enum {ERR_NONE, ERR_MISALIGN, ERR_FUNCT3, ERR_TIMEOUT}.
- One combinational sub-module, `load_align`: inputs rdata, addr[1:0], funct3; output 32-bit extended result.
- Counter width is `$clog2(BUS_TIMEOUT+1)`.

## Test plan
- LB from 0x1003, ack after 2 cycles with rdata 0x80FF_1234, rd = 5 → `bus_addr_o` 0x1000, `bus_be_o` 1000, then `rf_we_o` with rd 5, data 0xFFFF_FF80. Repeat as LBU → data 0x0000_0080.
- SH to 0x2002 with wdata 0x0000_BEEF, same-cycle ack → `bus_we_o` 1, `be` 1100, `wdata` 0xBEEF_BEEF, no `rf_we_o`, ready in cycle 2.
- LW from 0x2001 → `err_o` pulse with code 01, `bus_req_o` never asserts. funct3 = 011 → code 10.
- BUS_TIMEOUT = 4 with no ack → `bus_req_o` high 4 cycles then low, `err_o` with code 11, no writeback; the next request is accepted normally.
- LW to rd = 0 with rdata 0xDEAD_BEEF → `rf_we_o` never asserts, returns to IDLE the cycle after ack.
- Deassert `rst_ni` mid-BUS → `bus_req_o` drops asynchronously, no error pulse. After release, a valid LHU from 0x3002 with rdata 0xABCD_0000 writes 0x0000_ABCD.
